// File: rtl/seq_detect_param.sv
// Mealy serial-pattern detector with a runtime-programmable pattern of 1..PAT_W bits,
// selectable overlap mode, a registered match flag and a saturating match counter.
module seq_detect_param #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_seq,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             count_clr,
    output logic             out_seq,
    output logic             out_seq_q,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] MAX_FILL = LEN_W'(PAT_W - 1);
    localparam logic [PAT_W-1:0] RST_PAT  = PAT_W'(3'b110);
    localparam logic [LEN_W-1:0] RST_LEN  = LEN_W'(3);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] match_count_q, match_count_d;

    logic [LEN_W-1:0] eff_len;
    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic             pat_hit;
    logic             fill_ok;

    // window[0] is the incoming bit, window[k] the bit received k accepted bits earlier.
    always_comb begin
        eff_len = (len_q > MAX_LEN) ? MAX_LEN : len_q;
        window  = {hist_q, in_seq};
        mask    = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            if (LEN_W'(i) < eff_len) begin
                mask[i] = 1'b1;
            end
        end
        pat_hit = ((window ^ pat_q) & mask) == '0;
        fill_ok = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, eff_len};
        out_seq = reset && en && !cfg_load && (eff_len != '0) && fill_ok && pat_hit;
    end

    always_comb begin
        pat_d         = pat_q;
        len_d         = len_q;
        ovl_d         = ovl_q;
        hist_d        = hist_q;
        fill_d        = fill_q;
        match_count_d = match_count_q;

        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            ovl_d  = cfg_overlap;
            fill_d = '0;
        end else if (en) begin
            hist_d = window[PAT_W-2:0];
            if (out_seq && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q < MAX_FILL) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end

        if (count_clr) begin
            match_count_d = '0;
        end else if (out_seq && (match_count_q != '1)) begin
            match_count_d = match_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pat_q         <= RST_PAT;
            len_q         <= RST_LEN;
            ovl_q         <= 1'b1;
            hist_q        <= '0;
            fill_q        <= '0;
            match_count_q <= '0;
            out_seq_q     <= 1'b0;
        end else begin
            pat_q         <= pat_d;
            len_q         <= len_d;
            ovl_q         <= ovl_d;
            hist_q        <= hist_d;
            fill_q        <= fill_d;
            match_count_q <= match_count_d;
            out_seq_q     <= out_seq;
        end
    end

    assign match_count = match_count_q;

endmodule
